uart_rx: RTL and testbench

//  8N1 UART receiver; counterpart to the UART transmitter (same line format, same bit timing).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame width and default bit timing.
// Used by both the receiver and the transmitter so their encodings stay identical.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int CLOCKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uartState_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1
// so an idle-high line does not look like an edge coming out of reset.
module uart_sync2 (
    input  logic clk,
    input  logic resetN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples serialIn, samples each bit at mid-period, reassembles LSB first.
// Optional feature macro UART_RX_PARITY_EN adds a parity bit between data and stop plus parityError.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocksPerBit = CLOCKS_PER_BIT
) (
    input  logic                 clkRx,
    input  logic                 resetN,
    input  logic                 serialIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 frameError,
`ifdef UART_RX_PARITY_EN
    output logic                 parityError,
`endif
    output logic                 busy
);

    localparam int cntW      = $clog2(clocksPerBit);
    localparam int midCount  = (clocksPerBit - 1) / 2;
    localparam int lastCount = clocksPerBit - 1;

`ifdef UART_RX_PARITY_EN
    localparam logic parityOdd = 1'b0;
    logic parityBad, parityBadNext, parityErrorNext;
`endif

    uartState_e           state, stateNext;
    logic [cntW-1:0]      clkCount, clkCountNext;
    logic [2:0]           bitIndex, bitIndexNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic [DATA_BITS-1:0] dataOutNext;
    logic                 dataValidNext, frameErrorNext;
    logic                 rxS;
    logic                 bitDone;

    uart_sync2 rxSync (
        .clk    (clkRx),
        .resetN (resetN),
        .d      (serialIn),
        .q      (rxS)
    );

    assign bitDone = (clkCount == cntW'(lastCount));
    assign busy    = (state != IDLE);

    always_ff @(posedge clkRx or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            clkCount    <= '0;
            bitIndex    <= '0;
            shiftReg    <= '0;
            dataOut     <= '0;
            dataValid   <= 1'b0;
            frameError  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad   <= 1'b0;
            parityError <= 1'b0;
`endif
        end else begin
            state       <= stateNext;
            clkCount    <= clkCountNext;
            bitIndex    <= bitIndexNext;
            shiftReg    <= shiftNext;
            dataOut     <= dataOutNext;
            dataValid   <= dataValidNext;
            frameError  <= frameErrorNext;
`ifdef UART_RX_PARITY_EN
            parityBad   <= parityBadNext;
            parityError <= parityErrorNext;
`endif
        end
    end

    always_comb begin
        stateNext       = state;
        clkCountNext    = clkCount;
        bitIndexNext    = bitIndex;
        shiftNext       = shiftReg;
        dataOutNext     = dataOut;
        dataValidNext   = 1'b0;
        frameErrorNext  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBadNext   = parityBad;
        parityErrorNext = 1'b0;
`endif
        case (state)
            IDLE: begin
                clkCountNext = '0;
                bitIndexNext = '0;
                if (!rxS) stateNext = START;
            end
            // A start bit that is gone by mid-period is treated as noise.
            START: begin
                if (clkCount == cntW'(midCount)) begin
                    clkCountNext = '0;
                    stateNext    = rxS ? IDLE : DATA;
                end else begin
                    clkCountNext = clkCount + 1'b1;
                end
            end
            DATA: begin
                if (bitDone) begin
                    clkCountNext        = '0;
                    shiftNext[bitIndex] = rxS;
                    if (bitIndex == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end else begin
                        bitIndexNext = bitIndex + 1'b1;
                    end
                end else begin
                    clkCountNext = clkCount + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bitDone) begin
                    clkCountNext  = '0;
                    parityBadNext = (rxS != ((^shiftReg) ^ parityOdd));
                    stateNext     = STOP;
                end else begin
                    clkCountNext = clkCount + 1'b1;
                end
            end
`endif
            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            STOP: begin
                if (bitDone) begin
                    clkCountNext = '0;
                    if (rxS) begin
                        dataOutNext     = shiftReg;
                        dataValidNext   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parityErrorNext = parityBad;
`endif
                        stateNext       = IDLE;
                    end else begin
                        frameErrorNext = 1'b1;
                        stateNext      = WAIT_HIGH;
                    end
                end else begin
                    clkCountNext = clkCount + 1'b1;
                end
            end
            // A break or stuck-low line must see a high level before re-arming.
            WAIT_HIGH: begin
                clkCountNext = '0;
                if (rxS) stateNext = IDLE;
            end
            default: begin
                stateNext    = IDLE;
                clkCountNext = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes/frame errors queued at send time, popped on output pulses.
module tb_uart_rx;

    localparam int cpb = 87;

    typedef struct {
        bit         fe;
        logic [7:0] data;
        bit         par;
    } exp_t;

    logic       clkRx = 1'b0;
    logic       resetN = 1'b0;
    logic       serialIn = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid, frameError, busy;
`ifdef UART_RX_PARITY_EN
    logic       parityError;
    localparam int expLat = 2 + (cpb - 1) / 2 + 10 * cpb + 2;
`else
    localparam int expLat = 2 + (cpb - 1) / 2 + 9 * cpb + 2;
`endif

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         tFall = 0;
    int         lastLat = 0;
    logic [7:0] tbLastGood = 8'h00;
    exp_t       expQ[$];

    uart_rx #(.clocksPerBit(cpb)) dut (
        .clkRx       (clkRx),
        .resetN      (resetN),
        .serialIn    (serialIn),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .frameError  (frameError),
`ifdef UART_RX_PARITY_EN
        .parityError (parityError),
`endif
        .busy        (busy)
    );

    always #5 clkRx = ~clkRx;
    always @(posedge clkRx) cyc++;

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clkRx) begin
        exp_t e;
        if (resetN && (dataValid || frameError)) begin
            total++;
            if (dataValid && frameError) begin
                bad++;
                $display("FAIL pulse_overlap: dataValid=%b frameError=%b, required never both", dataValid, frameError);
            end else if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: dataValid=%b frameError=%b dataOut=%h, required no pulse", dataValid, frameError, dataOut);
            end else begin
                e = expQ.pop_front();
                if (dataValid) lastLat = cyc - tFall;
                if (frameError !== e.fe || dataOut !== e.data) begin
                    bad++;
                    $display("FAIL output_pulse: fe=%b dataOut=%h, required fe=%b dataOut=%h", frameError, dataOut, e.fe, e.data);
                end
`ifdef UART_RX_PARITY_EN
                else if (parityError !== (e.par & ~e.fe)) begin
                    bad++;
                    $display("FAIL parity_error: got %b, required %b", parityError, e.par & ~e.fe);
                end
`endif
            end
        end
    end

    task automatic driveBit(input logic b);
        serialIn = b;
        repeat (cpb) @(negedge clkRx);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic stopBit, input logic parFlip);
        tFall = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
        driveBit((^d) ^ parFlip);
`endif
        driveBit(stopBit);
    endtask

    task automatic pushGood(input logic [7:0] d, input bit par);
        exp_t e;
        e.fe = 1'b0; e.data = d; e.par = par;
        expQ.push_back(e);
        tbLastGood = d;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 3 * cpb && expQ.size() != 0; i++) @(negedge clkRx);
        repeat (2) @(negedge clkRx);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (5) @(negedge clkRx);
        total++;
        if (dataOut !== 8'h00 || dataValid !== 1'b0 || frameError !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: dataOut=%h dv=%b fe=%b busy=%b, required all 0", dataOut, dataValid, frameError, busy);
        end
`ifdef UART_RX_PARITY_EN
        total++;
        if (parityError !== 1'b0) begin
            bad++;
            $display("FAIL reset_parity: got %b, required 0", parityError);
        end
`endif
        resetN = 1'b1;
        repeat (2 * cpb) @(negedge clkRx);
    endtask

    task automatic test_byte();
        pushGood(8'hA5, 1'b0);
        sendByte(8'hA5, 1'b1, 1'b0);
        waitDrain();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL byte_a5_missing: pending=%0d, required 0", expQ.size());
        end
        total++;
        if (lastLat < expLat - 1 || lastLat > expLat + 1) begin
            bad++;
            $display("FAIL byte_latency: got %0d cycles, required %0d +/-1", lastLat, expLat);
        end
    endtask

    task automatic test_glitch();
        int n;
        serialIn = 1'b0;
        repeat (20) @(negedge clkRx);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy_high: got %b, required 1", busy);
        end
        serialIn = 1'b1;
        n = 20;
        while (busy !== 1'b0 && n < 2 + (cpb - 1) / 2 + 4) begin
            @(negedge clkRx);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy_low: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (2 * cpb) @(negedge clkRx);
    endtask

    task automatic test_frame_error();
        exp_t e;
        e.fe = 1'b1; e.data = tbLastGood; e.par = 1'b0;
        expQ.push_back(e);
        sendByte(8'h3C, 1'b0, 1'b0);
        serialIn = 1'b0;
        repeat (300) @(negedge clkRx);
        total++;
        if (busy !== 1'b1 || dataOut !== 8'hA5) begin
            bad++;
            $display("FAIL frame_hold: busy=%b dataOut=%h, required busy=1 dataOut=a5", busy, dataOut);
        end
        serialIn = 1'b1;
        repeat (6) @(negedge clkRx);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_rearm: busy=%b, required 0", busy);
        end
        repeat (cpb) @(negedge clkRx);
        pushGood(8'h81, 1'b0);
        sendByte(8'h81, 1'b1, 1'b0);
        waitDrain();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL frame_recover: pending=%0d, required 0", expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b2b [3];
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            pushGood(b2b[i], 1'b0);
            sendByte(b2b[i], 1'b1, 1'b0);
        end
        waitDrain();
        total++;
        if (expQ.size() != 0 || dataOut !== 8'h55) begin
            bad++;
            $display("FAIL back_to_back: pending=%0d dataOut=%h, required 0 and 55", expQ.size(), dataOut);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h77;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(d[i]);
        serialIn = d[4];
        repeat (cpb / 2) @(negedge clkRx);
        resetN = 1'b0;
        repeat (3) @(negedge clkRx);
        total++;
        if (dataOut !== 8'h00 || busy !== 1'b0 || dataValid !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: dataOut=%h busy=%b dv=%b, required 0/0/0", dataOut, busy, dataValid);
        end
        resetN = 1'b1;
        tbLastGood = 8'h00;
        serialIn = 1'b1;
        repeat (12 * cpb) @(negedge clkRx);
        total++;
        if (busy !== 1'b0 || dataOut !== 8'h00) begin
            bad++;
            $display("FAIL midframe_idle: busy=%b dataOut=%h, required 0/00", busy, dataOut);
        end
        pushGood(8'h12, 1'b0);
        sendByte(8'h12, 1'b1, 1'b0);
        waitDrain();
        total++;
        if (expQ.size() != 0 || dataOut !== 8'h12) begin
            bad++;
            $display("FAIL midframe_next: pending=%0d dataOut=%h, required 0 and 12", expQ.size(), dataOut);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        pushGood(8'h07, 1'b1);
        sendByte(8'h07, 1'b1, 1'b1);
        pushGood(8'h3C, 1'b0);
        sendByte(8'h3C, 1'b1, 1'b0);
        waitDrain();
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL parity_frames: pending=%0d, required 0", expQ.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL final_queue: pending=%0d, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
